// File: rtl/decode_execute_stage.sv
// Decode-to-execute pipeline register with MEM/WB operand forwarding,
// stale-operand refresh while stalled, and load-use bubble insertion.
// Optional performance counters are enabled by defining DEX_PERF_EN.
module decode_execute_stage #(
  parameter int unsigned CTRL_W = 8,
  parameter int unsigned PC_REG = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inValid,
  output logic              inReady,
  input  logic [3:0]        rn1,
  input  logic [3:0]        rn2,
  input  logic              use1,
  input  logic              use2,
  input  logic [3:0]        rd,
  input  logic              regWrite,
  input  logic              isLoad,
  input  logic [31:0]       readData1,
  input  logic [31:0]       readData2,
  input  logic [31:0]       imm,
  input  logic [CTRL_W-1:0] ctrl,
  input  logic              flush,
  input  logic              exReady,
  input  logic              memRegWrite,
  input  logic [3:0]        memRd,
  input  logic [31:0]       memResult,
  input  logic              wbRegWrite,
  input  logic [3:0]        wbRd,
  input  logic [31:0]       wbResult,
  output logic              outValid,
  output logic [31:0]       op1,
  output logic [31:0]       op2,
  output logic [31:0]       outImm,
  output logic [CTRL_W-1:0] outCtrl,
  output logic [3:0]        outRd,
  output logic              outRegWrite,
  output logic              outIsLoad
`ifdef DEX_PERF_EN
  ,
  output logic [31:0]       stallCycles,
  output logic [15:0]       bubbleCount
`endif
);

  localparam int unsigned AW = 4;
  localparam logic [AW-1:0] PC_ADDR = AW'(PC_REG);

  typedef enum logic {
    RUN    = 1'b0,
    BUBBLE = 1'b1
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic            adv;
  logic            hz;
  logic            capture;
  logic            enter_bubble;

  logic [AW-1:0]   rn1_q;
  logic [AW-1:0]   rn2_q;
  logic            use2_q;
  logic [31:0]     data1_q;
  logic [31:0]     data2_q;

  logic            mem_hit1;
  logic            mem_hit2;
  logic            wb_hit1;
  logic            wb_hit2;
  logic            wb_fix1;
  logic            wb_fix2;

  assign adv     = !outValid || exReady;
  assign hz      = outValid && outIsLoad && outRegWrite && (outRd != PC_ADDR) &&
                   ((use1 && (rn1 == outRd)) || (use2 && (rn2 == outRd)));
  assign capture = inValid && inReady;

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state, decode handshake and bubble entry
  always_comb begin
    state_d      = state_q;
    inReady      = 1'b0;
    enter_bubble = 1'b0;
    case (state_q)
      RUN: begin
        inReady      = adv && !hz;
        enter_bubble = hz && adv && inValid && !flush;
        if (enter_bubble) begin
          state_d = BUBBLE;
        end
      end
      BUBBLE: begin
        state_d = RUN;
      end
      default: begin
        state_d = RUN;
      end
    endcase
    if (flush) begin
      state_d = RUN;
    end
    if (!rst) begin
      inReady = 1'b0;
    end
  end

  // Held-operand refresh from WB while execute is stalled
  assign wb_fix1 = wbRegWrite && (wbRd == rn1_q) && (wbRd != PC_ADDR);
  assign wb_fix2 = wbRegWrite && (wbRd == rn2_q) && (wbRd != PC_ADDR);

  // Pipeline register: flush beats capture beats drain beats hold
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      outValid    <= 1'b0;
      rn1_q       <= '0;
      rn2_q       <= '0;
      use2_q      <= 1'b0;
      data1_q     <= '0;
      data2_q     <= '0;
      outImm      <= '0;
      outCtrl     <= '0;
      outRd       <= '0;
      outRegWrite <= 1'b0;
      outIsLoad   <= 1'b0;
    end else if (flush) begin
      outValid <= 1'b0;
    end else if (capture) begin
      outValid    <= 1'b1;
      rn1_q       <= rn1;
      rn2_q       <= rn2;
      use2_q      <= use2;
      data1_q     <= readData1;
      data2_q     <= readData2;
      outImm      <= imm;
      outCtrl     <= ctrl;
      outRd       <= rd;
      outRegWrite <= regWrite;
      outIsLoad   <= isLoad;
    end else if (adv) begin
      outValid <= 1'b0;
    end else begin
      if (wb_fix1) begin
        data1_q <= wbResult;
      end
      if (wb_fix2) begin
        data2_q <= wbResult;
      end
    end
  end

  assign mem_hit1 = memRegWrite && (memRd == rn1_q) && (rn1_q != PC_ADDR);
  assign mem_hit2 = memRegWrite && (memRd == rn2_q) && (rn2_q != PC_ADDR) && use2_q;
  assign wb_hit1  = wbRegWrite && (wbRd == rn1_q) && (rn1_q != PC_ADDR);
  assign wb_hit2  = wbRegWrite && (wbRd == rn2_q) && (rn2_q != PC_ADDR) && use2_q;

  // Operand forwarding, MEM has priority over WB over held data
  always_comb begin
    op1 = data1_q;
    op2 = data2_q;
    if (mem_hit1) begin
      op1 = memResult;
    end else if (wb_hit1) begin
      op1 = wbResult;
    end
    if (mem_hit2) begin
      op2 = memResult;
    end else if (wb_hit2) begin
      op2 = wbResult;
    end
  end

`ifdef DEX_PERF_EN
  // Saturating stall and bubble counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stallCycles <= '0;
      bubbleCount <= '0;
    end else begin
      if (inValid && !inReady && !(&stallCycles)) begin
        stallCycles <= stallCycles + 32'(1);
      end
      if (enter_bubble && !(&bubbleCount)) begin
        bubbleCount <= bubbleCount + 16'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_decode_execute_stage.sv
// Self-checking bench for decode_execute_stage: forwarding vector table
// with a scoreboard, plus hand-written hold, load-use, flush and reset sequences.
module tb_decode_execute_stage;

  logic        clk;
  logic        rst;
  logic        inValid;
  logic        inReady;
  logic [3:0]  rn1, rn2, rd;
  logic        use1, use2, regWrite, isLoad;
  logic [31:0] readData1, readData2, imm;
  logic [7:0]  ctrl;
  logic        flush, exReady;
  logic        memRegWrite, wbRegWrite;
  logic [3:0]  memRd, wbRd;
  logic [31:0] memResult, wbResult;
  logic        outValid;
  logic [31:0] op1, op2, outImm;
  logic [7:0]  outCtrl;
  logic [3:0]  outRd;
  logic        outRegWrite, outIsLoad;
`ifdef DEX_PERF_EN
  logic [31:0] stallCycles;
  logic [15:0] bubbleCount;
`endif

  int checks = 0;
  int errors = 0;

  decode_execute_stage #(.CTRL_W(8), .PC_REG(9)) dut (
    .clk(clk), .rst(rst), .inValid(inValid), .inReady(inReady),
    .rn1(rn1), .rn2(rn2), .use1(use1), .use2(use2), .rd(rd),
    .regWrite(regWrite), .isLoad(isLoad),
    .readData1(readData1), .readData2(readData2), .imm(imm), .ctrl(ctrl),
    .flush(flush), .exReady(exReady),
    .memRegWrite(memRegWrite), .memRd(memRd), .memResult(memResult),
    .wbRegWrite(wbRegWrite), .wbRd(wbRd), .wbResult(wbResult),
    .outValid(outValid), .op1(op1), .op2(op2), .outImm(outImm),
    .outCtrl(outCtrl), .outRd(outRd), .outRegWrite(outRegWrite), .outIsLoad(outIsLoad)
`ifdef DEX_PERF_EN
    , .stallCycles(stallCycles), .bubbleCount(bubbleCount)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  r1, r2, d;
    logic        u2, rw, ld;
    logic [31:0] a, b, im;
    logic [7:0]  c;
    logic        mrw, wrw;
    logic [3:0]  mrd, wrd;
    logic [31:0] mres, wres;
    logic [31:0] e1, e2;
  } vec_t;

  typedef struct {
    logic [31:0] op1, op2, imm;
    logic [7:0]  ctrl;
    logic [3:0]  rd;
    logic        rw, ld;
  } exp_t;

  vec_t vecs[8];
  exp_t sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input logic [3:0] r1, input logic [3:0] r2, input logic u1,
                           input logic u2, input logic [3:0] d, input logic rw,
                           input logic ld, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] im, input logic [7:0] c);
    rn1 = r1; rn2 = r2; use1 = u1; use2 = u2; rd = d; regWrite = rw; isLoad = ld;
    readData1 = a; readData2 = b; imm = im; ctrl = c;
  endtask

  task automatic clear_fwd();
    memRegWrite = 1'b0; memRd = 4'd0; memResult = 32'h0;
    wbRegWrite = 1'b0; wbRd = 4'd0; wbResult = 32'h0;
  endtask

  initial begin
    vecs[0] = '{r1:2,  r2:1,  d:5, u2:1, rw:1, ld:0, a:32'h11,  b:32'h22,  im:32'h40, c:8'h01,
                mrw:0, wrw:0, mrd:0,  wrd:0,  mres:32'h0,  wres:32'h0,  e1:32'h11,  e2:32'h22};
    vecs[1] = '{r1:3,  r2:1,  d:3, u2:1, rw:1, ld:0, a:32'h33,  b:32'h01,  im:32'h0,  c:8'h02,
                mrw:1, wrw:1, mrd:3,  wrd:3,  mres:32'hAA, wres:32'hBB, e1:32'hAA,  e2:32'h01};
    vecs[2] = '{r1:5,  r2:5,  d:7, u2:1, rw:0, ld:0, a:32'h50,  b:32'h51,  im:32'h4,  c:8'h80,
                mrw:0, wrw:1, mrd:5,  wrd:5,  mres:32'hAA, wres:32'hBB, e1:32'hBB,  e2:32'hBB};
    vecs[3] = '{r1:1,  r2:9,  d:2, u2:1, rw:1, ld:0, a:32'h10,  b:32'h108, im:32'hFFFF_FFFF, c:8'hFF,
                mrw:1, wrw:0, mrd:9,  wrd:0,  mres:32'hCC, wres:32'h0,  e1:32'h10,  e2:32'h108};
    vecs[4] = '{r1:1,  r2:6,  d:1, u2:0, rw:1, ld:0, a:32'h10,  b:32'h66,  im:32'h8,  c:8'h10,
                mrw:1, wrw:0, mrd:6,  wrd:0,  mres:32'hCC, wres:32'h0,  e1:32'h10,  e2:32'h66};
    vecs[5] = '{r1:1,  r2:6,  d:1, u2:1, rw:1, ld:0, a:32'h10,  b:32'h66,  im:32'h8,  c:8'h11,
                mrw:1, wrw:0, mrd:6,  wrd:0,  mres:32'hCC, wres:32'h0,  e1:32'h10,  e2:32'hCC};
    vecs[6] = '{r1:12, r2:15, d:15, u2:1, rw:1, ld:0, a:32'hC0, b:32'hF0,  im:32'h12, c:8'h5A,
                mrw:1, wrw:1, mrd:15, wrd:12, mres:32'hEE, wres:32'hDD, e1:32'hDD,  e2:32'hEE};
    vecs[7] = '{r1:9,  r2:9,  d:9, u2:1, rw:1, ld:1, a:32'h108, b:32'h108, im:32'h9,  c:8'hA5,
                mrw:1, wrw:1, mrd:9,  wrd:9,  mres:32'hEE, wres:32'hDD, e1:32'h108, e2:32'h108};
  end

  initial begin
    exp_t e;
    rst = 1'b0; inValid = 1'b0; flush = 1'b0; exReady = 1'b1;
    set_instr(4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 8'h0);
    clear_fwd();

    // Reset state
    #13;
    chk("rst_outValid", 32'(outValid), 32'd0);
    chk("rst_inReady", 32'(inReady), 32'd0);
    chk("rst_op1", op1, 32'h0);
    chk("rst_outImm", outImm, 32'h0);
`ifdef DEX_PERF_EN
    chk("rst_stall", stallCycles, 32'd0);
    chk("rst_bubble", 32'(bubbleCount), 32'd0);
`endif
    rst = 1'b1;
    tick();

    // Forwarding vector table through the scoreboard
    for (int i = 0; i < 8; i++) begin
      set_instr(vecs[i].r1, vecs[i].r2, 1'b1, vecs[i].u2, vecs[i].d, vecs[i].rw, vecs[i].ld,
                vecs[i].a, vecs[i].b, vecs[i].im, vecs[i].c);
      clear_fwd();
      inValid = 1'b1;
      #1;
      chk("vec_inReady", 32'(inReady), 32'd1);
      sb.push_back('{op1:vecs[i].e1, op2:vecs[i].e2, imm:vecs[i].im, ctrl:vecs[i].c,
                     rd:vecs[i].d, rw:vecs[i].rw, ld:vecs[i].ld});
      tick();
      inValid = 1'b0;
      memRegWrite = vecs[i].mrw; memRd = vecs[i].mrd; memResult = vecs[i].mres;
      wbRegWrite = vecs[i].wrw; wbRd = vecs[i].wrd; wbResult = vecs[i].wres;
      #1;
      chk("vec_outValid", 32'(outValid), 32'd1);
      if (sb.size() == 0) begin
        chk("vec_sb_empty", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("vec_op1", op1, e.op1);
        chk("vec_op2", op2, e.op2);
        chk("vec_imm", outImm, e.imm);
        chk("vec_ctrl", 32'(outCtrl), 32'(e.ctrl));
        chk("vec_rd", 32'(outRd), 32'(e.rd));
        chk("vec_rw", 32'(outRegWrite), 32'(e.rw));
        chk("vec_ld", 32'(outIsLoad), 32'(e.ld));
      end
      clear_fwd();
      tick();
      chk("vec_drain", 32'(outValid), 32'd0);
    end

    // Hold for 3 cycles with a WB write to the held source in the 2nd
    set_instr(4'd7, 4'd8, 1'b1, 1'b1, 4'd2, 1'b1, 1'b0, 32'h77, 32'h88, 32'h3, 8'h3);
    inValid = 1'b1;
    tick();
    inValid = 1'b0; exReady = 1'b0;
    #1;
    chk("hold_c1_op1", op1, 32'h77);
    chk("hold_c1_inReady", 32'(inReady), 32'd0);
    tick();
    wbRegWrite = 1'b1; wbRd = 4'd7; wbResult = 32'h55;
    #1;
    chk("hold_c2_op1", op1, 32'h55);
    tick();
    clear_fwd();
    #1;
    chk("hold_c3_valid", 32'(outValid), 32'd1);
    chk("hold_c3_op1", op1, 32'h55);
    chk("hold_c3_op2", op2, 32'h88);
    exReady = 1'b1;
    #1;
    chk("hold_rel_op1", op1, 32'h55);
    tick();
    chk("hold_drain", 32'(outValid), 32'd0);

    // Load-use hazard: bubble then capture
    set_instr(4'd1, 4'd2, 1'b1, 1'b0, 4'd4, 1'b1, 1'b1, 32'h1, 32'h2, 32'h0, 8'h0);
    inValid = 1'b1;
    tick();
    set_instr(4'd4, 4'd3, 1'b1, 1'b0, 4'd1, 1'b1, 1'b0, 32'h44, 32'h33, 32'h6, 8'h6);
    #1;
    chk("lu_hz_inReady", 32'(inReady), 32'd0);
    tick();
    chk("lu_bubble_valid", 32'(outValid), 32'd0);
    chk("lu_bubble_inReady", 32'(inReady), 32'd0);
    tick();
    chk("lu_run_inReady", 32'(inReady), 32'd1);
    chk("lu_run_valid", 32'(outValid), 32'd0);
    tick();
    inValid = 1'b0;
    chk("lu_cap_valid", 32'(outValid), 32'd1);
    chk("lu_cap_op1", op1, 32'h44);
`ifdef DEX_PERF_EN
    chk("lu_bubble_cnt", 32'(bubbleCount), 32'd1);
    chk("lu_stall_cnt", stallCycles, 32'd2);
`endif
    tick();

    // Flush during hold with a new instruction offered
    set_instr(4'd1, 4'd2, 1'b1, 1'b1, 4'd5, 1'b1, 1'b0, 32'h91, 32'h92, 32'h90, 8'h9);
    inValid = 1'b1;
    tick();
    exReady = 1'b0; flush = 1'b1;
    set_instr(4'd3, 4'd2, 1'b1, 1'b1, 4'd6, 1'b1, 1'b0, 32'hA1, 32'hA2, 32'hA0, 8'hA);
    tick();
    chk("fl_hold_valid", 32'(outValid), 32'd0);
    flush = 1'b0; inValid = 1'b0; exReady = 1'b1;
    #1;
    chk("fl_hold_run", 32'(inReady), 32'd1);

    // Flush beats a capture on the same edge
    inValid = 1'b1;
    tick();
    chk("fl_cap_pre", 32'(outValid), 32'd1);
    flush = 1'b1;
    #1;
    chk("fl_cap_inReady", 32'(inReady), 32'd1);
    tick();
    chk("fl_cap_valid", 32'(outValid), 32'd0);
    flush = 1'b0;

    // Flush together with a load-use hazard: no bubble
    set_instr(4'd1, 4'd2, 1'b1, 1'b0, 4'd4, 1'b1, 1'b1, 32'h1, 32'h2, 32'h0, 8'h0);
    tick();
    set_instr(4'd4, 4'd3, 1'b1, 1'b0, 4'd1, 1'b1, 1'b0, 32'h44, 32'h33, 32'h6, 8'h6);
    flush = 1'b1;
    #1;
    chk("flhz_inReady", 32'(inReady), 32'd0);
    tick();
    flush = 1'b0; inValid = 1'b0;
    #1;
    chk("flhz_valid", 32'(outValid), 32'd0);
    chk("flhz_run", 32'(inReady), 32'd1);
`ifdef DEX_PERF_EN
    chk("flhz_bubble_cnt", 32'(bubbleCount), 32'd1);
    chk("flhz_stall_cnt", stallCycles, 32'd4);
`endif

    // Reset asserted mid-BUBBLE
    set_instr(4'd1, 4'd2, 1'b1, 1'b0, 4'd4, 1'b1, 1'b1, 32'h1, 32'h2, 32'h77, 8'h7);
    inValid = 1'b1;
    tick();
    set_instr(4'd4, 4'd3, 1'b1, 1'b0, 4'd1, 1'b1, 1'b0, 32'h44, 32'h33, 32'h6, 8'h6);
    tick();
    chk("rb_in_bubble", 32'(inReady), 32'd0);
    #2 rst = 1'b0;
    #1;
    chk("rb_valid", 32'(outValid), 32'd0);
    chk("rb_inReady", 32'(inReady), 32'd0);
    chk("rb_outRd", 32'(outRd), 32'd0);
`ifdef DEX_PERF_EN
    chk("rb_bubble_cnt", 32'(bubbleCount), 32'd0);
`endif
    inValid = 1'b0;
    #2 rst = 1'b1;
    tick();
    chk("rb_run", 32'(inReady), 32'd1);
    chk("rb_idle_valid", 32'(outValid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
